// File: rtl/sfx_tone_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sfx_tone_sequencer_if : event strobes, per-event tone config, speaker outputs
// Revision: 1.0
// ============================================================================
interface sfx_tone_sequencer_if #(
   parameter int N_EVT  = 4,
   parameter int HALF_W = 20,
   parameter int DUR_W  = 8,
   parameter int IDX_W  = 4
);
   logic [N_EVT-1:0]        evt;
   logic [N_EVT*HALF_W-1:0] tone_half;
   logic [N_EVT*DUR_W-1:0]  dur;
   logic                    mute;
   logic                    speaker;
   logic                    busy;
   logic [IDX_W-1:0]        active_idx;
   logic                    done;

   modport master (
      output evt, tone_half, dur, mute,
      input  speaker, busy, active_idx, done
   );

   modport slave (
      input  evt, tone_half, dur, mute,
      output speaker, busy, active_idx, done
   );
endinterface
`default_nettype wire

// File: rtl/sfx_tone_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sfx_tone_sequencer : priority-preemptive square-wave sound-effect engine
// Revision: 1.0
// ============================================================================
module sfx_tone_sequencer #(
   parameter int N_EVT    = 4,
   parameter int HALF_W   = 20,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 50000,
   parameter int IDX_W    = 4
) (
   input  wire logic           clk,
   input  wire logic           reset,
   sfx_tone_sequencer_if.slave bus
);

   localparam int c_PRESC_W = $clog2(TICK_DIV);
   localparam int c_SLOTS   = 1 << IDX_W;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } state_t;

   state_t                 r_state, w_state_nx;
   logic [N_EVT-1:0]       r_pending, w_pending_nx;
   logic [IDX_W-1:0]       r_idx, w_idx_nx;
   logic [HALF_W-1:0]      r_phase, w_phase_nx;
   logic                   r_tone, w_tone_nx;
   logic                   r_speaker, w_speaker_nx;
   logic [c_PRESC_W-1:0]   r_presc, w_presc_nx;
   logic [DUR_W-1:0]       r_dcnt, w_dcnt_nx;
   logic                   r_done, w_done_nx;
   logic                   r_busy, w_busy_nx;

   logic [HALF_W-1:0]      w_half_arr [c_SLOTS];
   logic [DUR_W-1:0]       w_dur_arr  [c_SLOTS];
   logic                   w_pend_any;
   logic [IDX_W-1:0]       w_sel;
   logic [N_EVT-1:0]       w_sel_mask;
   logic [N_EVT-1:0]       w_play_mask;
   logic [N_EVT-1:0]       w_clr_mask;
   logic                   w_load;
   logic                   w_tick;
   logic                   w_retrig;

   // Unpack the flat config buses into index-addressable tables; slots beyond
   // N_EVT read as zero so any IDX_W-wide index is in range.
   generate
      for (genvar g = 0; g < c_SLOTS; g++) begin : g_slot
         if (g < N_EVT) begin : g_used
            assign w_half_arr[g] = bus.tone_half[g*HALF_W +: HALF_W];
            assign w_dur_arr[g]  = bus.dur[g*DUR_W +: DUR_W];
         end else begin : g_unused
            assign w_half_arr[g] = '0;
            assign w_dur_arr[g]  = '0;
         end
      end
   endgenerate

   always_comb begin
      w_sel = '0;
      for (int k = N_EVT - 1; k >= 0; k--) begin
         if (r_pending[k]) begin
            w_sel = IDX_W'(k);
         end
      end
   end

   assign w_pend_any  = |r_pending;
   assign w_sel_mask  = N_EVT'(1) << w_sel;
   assign w_play_mask = (r_state == S_PLAY) ? (N_EVT'(1) << r_idx) : '0;
   assign w_retrig    = |(bus.evt & w_play_mask);
   assign w_tick      = (r_presc == c_PRESC_MAX);

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_phase_nx = r_phase;
      w_tone_nx  = r_tone;
      w_presc_nx = r_presc;
      w_dcnt_nx  = r_dcnt;
      w_done_nx  = 1'b0;
      w_busy_nx  = r_busy;
      w_clr_mask = '0;
      w_load     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tone_nx = 1'b0;
            if (w_pend_any) begin
               w_clr_mask = w_sel_mask;
               w_load     = (w_dur_arr[w_sel] != '0);
            end
         end
         S_PLAY: begin
            // A zero-duration pre-emptor is discarded and the current tone runs on.
            if (w_pend_any && (w_sel < r_idx)) begin
               w_clr_mask = w_sel_mask;
               w_load     = (w_dur_arr[w_sel] != '0);
            end
            if (!w_load) begin
               if (r_phase == '0) begin
                  w_phase_nx = w_half_arr[r_idx] - HALF_W'(1);
                  w_tone_nx  = (w_half_arr[r_idx] == '0) ? 1'b0 : ~r_tone;
               end else begin
                  w_phase_nx = r_phase - HALF_W'(1);
               end

               w_presc_nx = w_tick ? '0 : (r_presc + c_PRESC_W'(1));

               // Retrigger outranks a coincident final tick.
               if (w_retrig) begin
                  w_presc_nx = '0;
                  w_dcnt_nx  = w_dur_arr[r_idx];
               end else if (w_tick) begin
                  if (r_dcnt == DUR_W'(1)) begin
                     w_state_nx = S_IDLE;
                     w_busy_nx  = 1'b0;
                     w_idx_nx   = '0;
                     w_tone_nx  = 1'b0;
                     w_done_nx  = 1'b1;
                     w_dcnt_nx  = '0;
                  end else begin
                     w_dcnt_nx = r_dcnt - DUR_W'(1);
                  end
               end
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase

      if (w_load) begin
         w_state_nx = S_PLAY;
         w_busy_nx  = 1'b1;
         w_idx_nx   = w_sel;
         w_phase_nx = w_half_arr[w_sel] - HALF_W'(1);
         w_tone_nx  = 1'b0;
         w_presc_nx = '0;
         w_dcnt_nx  = w_dur_arr[w_sel];
      end

      w_pending_nx = (r_pending & ~w_clr_mask) | (bus.evt & ~w_play_mask);
      w_speaker_nx = w_tone_nx & ~bus.mute;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_idx     <= '0;
         r_phase   <= '0;
         r_tone    <= 1'b0;
         r_speaker <= 1'b0;
         r_presc   <= '0;
         r_dcnt    <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_pending <= w_pending_nx;
         r_idx     <= w_idx_nx;
         r_phase   <= w_phase_nx;
         r_tone    <= w_tone_nx;
         r_speaker <= w_speaker_nx;
         r_presc   <= w_presc_nx;
         r_dcnt    <= w_dcnt_nx;
         r_done    <= w_done_nx;
         r_busy    <= w_busy_nx;
      end
   end

   assign bus.speaker    = r_speaker;
   assign bus.busy       = r_busy;
   assign bus.active_idx = r_idx;
   assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sfx_tone_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sfx_tone_sequencer : directed and random stimulus against a timing model
// Revision: 1.0
// ============================================================================
module tb_sfx_tone_sequencer;

   localparam int N_EVT    = 4;
   localparam int HALF_W   = 20;
   localparam int DUR_W    = 8;
   localparam int TICK_DIV = 10;
   localparam int IDX_W    = 4;

   int HALF [N_EVT] = '{3, 5, 7, 2};
   int DUR  [N_EVT] = '{4, 2, 3, 0};

   logic clk = 1'b0;
   logic reset;
   logic mute_r;

   sfx_tone_sequencer_if #(.N_EVT(N_EVT), .HALF_W(HALF_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) bus ();

   sfx_tone_sequencer #(
      .N_EVT(N_EVT), .HALF_W(HALF_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV), .IDX_W(IDX_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int busy_cnt, done_cnt, spk_cnt;

   // Timing model: a tone is described by its load edge and its end edge.
   bit        m_busy, m_done, m_spk;
   int        m_idx, m_t0, m_tend;
   bit [3:0]  m_pend;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_spk = 0; m_idx = 0; m_t0 = 0; m_tend = 0; m_pend = '0;
   endtask

   function automatic int lowest(input bit [3:0] p);
      for (int i = 0; i < N_EVT; i++) if (p[i]) return i;
      return -1;
   endfunction

   task automatic model_edge(input bit [3:0] e, input bit m);
      bit [3:0] clr, keep;
      bit was_busy, loaded;
      int was_idx, j;
      was_busy = m_busy; was_idx = m_idx;
      clr = '0; loaded = 0; m_done = 0;
      j = lowest(m_pend);
      if (j >= 0 && (!m_busy || j < m_idx)) begin
         clr[j] = 1'b1;
         if (DUR[j] != 0) begin
            m_busy = 1; m_idx = j; m_t0 = cyc; m_tend = cyc + DUR[j] * TICK_DIV; loaded = 1;
         end
      end
      if (was_busy && !loaded) begin
         if (e[m_idx]) m_tend = cyc + DUR[m_idx] * TICK_DIV;
         else if (cyc == m_tend) begin
            m_busy = 0; m_done = 1; m_idx = 0;
         end
      end
      keep = was_busy ? (4'b0001 << was_idx) : 4'b0000;
      m_pend = (m_pend & ~clr) | (e & ~keep);
      m_spk = m_busy && (HALF[m_idx] != 0) && ((((cyc - m_t0) / HALF[m_idx]) % 2) == 1) && !m;
   endtask

   task automatic check_outputs();
      check("speaker",    32'(bus.speaker),    32'(m_spk));
      check("busy",       32'(bus.busy),       32'(m_busy));
      check("active_idx", 32'(bus.active_idx), 32'(m_idx));
      check("done",       32'(bus.done),       32'(m_done));
   endtask

   task automatic step(input bit [3:0] e);
      bus.evt  = e;
      bus.mute = mute_r;
      @(posedge clk);
      cyc++;
      model_edge(e, mute_r);
      #1;
      bus.evt = '0;
      check_outputs();
      if (bus.busy)    busy_cnt++;
      if (bus.done)    done_cnt++;
      if (bus.speaker) spk_cnt++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(4'b0000);
   endtask

   task automatic clear_counts();
      busy_cnt = 0; done_cnt = 0; spk_cnt = 0;
   endtask

   initial begin
      reset  = 1'b1;
      mute_r = 1'b0;
      bus.evt  = '0;
      bus.mute = 1'b0;
      for (int i = 0; i < N_EVT; i++) begin
         bus.tone_half[i*HALF_W +: HALF_W] = HALF_W'(HALF[i]);
         bus.dur[i*DUR_W +: DUR_W]         = DUR_W'(DUR[i]);
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_speaker", 32'(bus.speaker),    32'd0);
      check("rst_busy",    32'(bus.busy),       32'd0);
      check("rst_idx",     32'(bus.active_idx), 32'd0);
      check("rst_done",    32'(bus.done),       32'd0);
      reset = 1'b0;
      idle(3);

      // Single event 1
      clear_counts();
      step(4'b0010);
      idle(25);
      check("single_busy_len", 32'(busy_cnt), 32'd20);
      check("single_done_cnt", 32'(done_cnt), 32'd1);

      // Simultaneous 1 and 2
      clear_counts();
      step(4'b0110);
      idle(60);
      check("simul_busy_len", 32'(busy_cnt), 32'd50);
      check("simul_done_cnt", 32'(done_cnt), 32'd2);

      // Event 2 pre-empted by event 0
      clear_counts();
      step(4'b0100);
      idle(7);
      step(4'b0001);
      idle(50);
      check("preempt_busy_len", 32'(busy_cnt), 32'd48);
      check("preempt_done_cnt", 32'(done_cnt), 32'd1);

      // Retrigger event 1, then a zero-duration event 3
      clear_counts();
      step(4'b0010);
      idle(14);
      step(4'b0010);
      idle(25);
      check("retrig_busy_len", 32'(busy_cnt), 32'd34);
      check("retrig_done_cnt", 32'(done_cnt), 32'd1);
      clear_counts();
      step(4'b1000);
      idle(5);
      check("zero_dur_busy", 32'(busy_cnt), 32'd0);
      check("zero_dur_done", 32'(done_cnt), 32'd0);

      // Mute through the middle of an event 0 tone
      clear_counts();
      step(4'b0001);
      idle(5);
      mute_r = 1'b1;
      spk_cnt = 0;
      idle(20);
      check("mute_speaker_hi", 32'(spk_cnt), 32'd0);
      mute_r = 1'b0;
      idle(20);
      check("mute_busy_len", 32'(busy_cnt), 32'd40);
      check("mute_done_cnt", 32'(done_cnt), 32'd1);

      // Asynchronous reset mid-tone with event 2 pending behind event 0
      step(4'b0001);
      idle(10);
      step(4'b0100);
      idle(3);
      reset = 1'b1;
      #1;
      check("async_rst_speaker", 32'(bus.speaker),    32'd0);
      check("async_rst_busy",    32'(bus.busy),       32'd0);
      check("async_rst_idx",     32'(bus.active_idx), 32'd0);
      check("async_rst_done",    32'(bus.done),       32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_counts();
      idle(30);
      check("rst_pending_lost", 32'(busy_cnt), 32'd0);

      // Random strobes and mute changes
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 49) == 0) mute_r = ~mute_r;
         if ($urandom_range(0, 11) == 0) step(4'($urandom_range(1, 15)));
         else                            step(4'b0000);
      end
      mute_r = 1'b0;
      idle(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
